// File: rtl/fme_mv_nbr_buffer.sv
// Neighbour MV store for FME/MC: ping-pong left column banks, top line buffer with
// per-entry availability, write-priority port arbitration and top-left corner capture.
module fme_mv_nbr_buffer #(
   parameter int unsigned MV_W    = 10,
   parameter int unsigned GL      = 3,
   parameter int unsigned CTU_X_W = 7
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    frame_start_i,
   input  logic                    ctu_start_i,
   input  logic [CTU_X_W-1:0]      ctu_x_i,
   input  logic                    wr_valid_i,
   output logic                    wr_ready_o,
   input  logic [GL-1:0]           wr_row_i,
   input  logic [GL-1:0]           wr_col_i,
   input  logic [2*MV_W-1:0]       wr_mv_i,
   input  logic                    lft_rd_en_i,
   input  logic [GL-1:0]           lft_rd_row_i,
   output logic [2*MV_W-1:0]       lft_rd_mv_o,
   output logic                    lft_rd_avail_o,
   input  logic                    top_rd_en_i,
   output logic                    top_rd_ready_o,
   input  logic [CTU_X_W+GL-1:0]   top_rd_x_i,
   output logic [2*MV_W-1:0]       top_rd_mv_o,
   output logic                    top_rd_avail_o
);
   localparam int unsigned G     = 1 << GL;
   localparam int unsigned D_W   = 2 * MV_W;
   localparam int unsigned TA_W  = CTU_X_W + GL;
   localparam int unsigned DEPTH = 1 << TA_W;

   typedef enum logic {W_IDLE, W_CAP} wstate_t;
   wstate_t state_q, state_d;

   logic            wr_acc, wr_commit, is_bot, is_rcol, is_corner;
   logic            port_busy, top_acc, is_tl, is_wrap;
   logic            mem_we, mem_re;
   logic [TA_W-1:0] wr_addr, tl_x, port_addr, cap_addr;
   logic [D_W-1:0]  port_data, cap_mv, mem_q;
   logic            cap_av;

   logic [D_W-1:0]   top_mem [DEPTH];
   logic [DEPTH-1:0] top_av;
   logic [D_W-1:0]   lft_mv [2][G];
   logic [G-1:0]     lft_av [2];

   logic [D_W-1:0]  tl_pend_mv, tl_sh_mv, top_mv_q;
   logic            tl_pend_av, tl_sh_av, top_sel_q;

   assign is_bot    = (wr_row_i == GL'(G - 1));
   assign is_rcol   = (wr_col_i == GL'(G - 1));
   assign is_corner = is_bot & is_rcol;
   assign wr_acc    = wr_valid_i & wr_ready_o;
   // frame start wins over a coincident write: the request is consumed but dropped
   assign wr_commit = wr_acc & ~frame_start_i;
   assign wr_addr   = {ctu_x_i, wr_col_i};
   assign tl_x      = {ctu_x_i, {GL{1'b0}}} - TA_W'(1);

   assign port_busy      = (state_q == W_CAP) | (wr_acc & is_bot);
   assign top_rd_ready_o = ~port_busy;
   assign top_acc        = top_rd_en_i & ~port_busy;
   assign is_tl          = (ctu_x_i != '0) && (top_rd_x_i == tl_x);
   assign is_wrap        = (ctu_x_i == '0) && (top_rd_x_i == '1);

   // Write FSM and single-port array control
   always_comb begin
      state_d   = state_q;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      port_addr = top_rd_x_i;
      port_data = wr_mv_i;
      case (state_q)
         W_IDLE: begin
            if (wr_commit && is_bot) begin
               port_addr = wr_addr;
               if (is_rcol) begin
                  mem_re  = 1'b1;
                  state_d = W_CAP;
               end else begin
                  mem_we  = 1'b1;
               end
            end else if (top_acc) begin
               mem_re = 1'b1;
            end
         end
         W_CAP: begin
            mem_we    = 1'b1;
            port_addr = cap_addr;
            port_data = cap_mv;
            state_d   = W_IDLE;
         end
         default: state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= W_IDLE;
         wr_ready_o <= 1'b1;
         cap_addr   <= '0;
         cap_mv     <= '0;
         cap_av     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ready_o <= (state_d == W_IDLE);
         if (wr_commit && is_corner) begin
            cap_addr <= wr_addr;
            cap_mv   <= wr_mv_i;
            cap_av   <= top_av[wr_addr];
         end
      end
   end

   // Top line storage, no reset on data
   always_ff @(posedge clk) begin
      if (mem_we)
         top_mem[port_addr] <= port_data;
      else if (mem_re)
         mem_q <= top_mem[port_addr];
   end

   // Availability and top-left pending/shadow
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         top_av     <= '0;
         tl_pend_mv <= '0;
         tl_pend_av <= 1'b0;
         tl_sh_mv   <= '0;
         tl_sh_av   <= 1'b0;
      end else if (frame_start_i) begin
         top_av     <= '0;
         tl_pend_mv <= '0;
         tl_pend_av <= 1'b0;
         tl_sh_mv   <= '0;
         tl_sh_av   <= 1'b0;
      end else begin
         if (mem_we)
            top_av[port_addr] <= 1'b1;
         if (state_q == W_CAP) begin
            tl_pend_mv <= mem_q;
            tl_pend_av <= cap_av;
         end
         if (ctu_start_i) begin
            tl_sh_mv <= tl_pend_mv;
            tl_sh_av <= tl_pend_av;
         end
      end
   end

   // Top read result; array data is copied out after one cycle so the output holds
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         top_sel_q      <= 1'b0;
         top_mv_q       <= '0;
         top_rd_avail_o <= 1'b0;
      end else if (top_acc) begin
         top_sel_q      <= ~is_tl & ~is_wrap;
         top_mv_q       <= is_tl ? tl_sh_mv : '0;
         top_rd_avail_o <= is_tl ? tl_sh_av : (~is_wrap & top_av[top_rd_x_i]);
      end else if (top_sel_q) begin
         top_sel_q <= 1'b0;
         top_mv_q  <= mem_q;
      end
   end

   assign top_rd_mv_o = top_sel_q ? mem_q : top_mv_q;

   // Left ping-pong banks
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int b = 0; b < 2; b++) begin
            lft_av[b] <= '0;
            for (int g = 0; g < G; g++)
               lft_mv[b][g] <= '0;
         end
         lft_rd_mv_o    <= '0;
         lft_rd_avail_o <= 1'b0;
      end else begin
         if (frame_start_i) begin
            lft_av[0] <= '0;
            lft_av[1] <= '0;
         end else if (wr_commit && is_rcol) begin
            lft_mv[ctu_x_i[0]][wr_row_i] <= wr_mv_i;
            lft_av[ctu_x_i[0]][wr_row_i] <= 1'b1;
         end
         if (lft_rd_en_i) begin
            if (ctu_x_i == '0) begin
               lft_rd_mv_o    <= '0;
               lft_rd_avail_o <= 1'b0;
            end else begin
               lft_rd_mv_o    <= lft_mv[~ctu_x_i[0]][lft_rd_row_i];
               lft_rd_avail_o <= lft_av[~ctu_x_i[0]][lft_rd_row_i];
            end
         end
      end
   end
endmodule

// File: tb/tb_fme_mv_nbr_buffer.sv
// Directed bench for fme_mv_nbr_buffer: left/top reads, corner capture, frame start and reset abort.
module tb_fme_mv_nbr_buffer;
   logic        clk = 1'b0;
   logic        rstn;
   logic        frame_start_i, ctu_start_i;
   logic [6:0]  ctu_x_i;
   logic        wr_valid_i, wr_ready_o;
   logic [2:0]  wr_row_i, wr_col_i;
   logic [19:0] wr_mv_i;
   logic        lft_rd_en_i;
   logic [2:0]  lft_rd_row_i;
   logic [19:0] lft_rd_mv_o;
   logic        lft_rd_avail_o;
   logic        top_rd_en_i, top_rd_ready_o;
   logic [9:0]  top_rd_x_i;
   logic [19:0] top_rd_mv_o;
   logic        top_rd_avail_o;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [19:0] MV_A = 20'hAAAAA;
   localparam logic [19:0] MV_B = 20'h5B5B5;

   fme_mv_nbr_buffer dut (
      .clk(clk), .rstn(rstn), .frame_start_i(frame_start_i), .ctu_start_i(ctu_start_i),
      .ctu_x_i(ctu_x_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
      .wr_row_i(wr_row_i), .wr_col_i(wr_col_i), .wr_mv_i(wr_mv_i),
      .lft_rd_en_i(lft_rd_en_i), .lft_rd_row_i(lft_rd_row_i), .lft_rd_mv_o(lft_rd_mv_o),
      .lft_rd_avail_o(lft_rd_avail_o), .top_rd_en_i(top_rd_en_i),
      .top_rd_ready_o(top_rd_ready_o), .top_rd_x_i(top_rd_x_i), .top_rd_mv_o(top_rd_mv_o),
      .top_rd_avail_o(top_rd_avail_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [2:0] row, input logic [2:0] col, input logic [19:0] mv);
      bit done = 0;
      wr_valid_i = 1'b1; wr_row_i = row; wr_col_i = col; wr_mv_i = mv;
      for (int i = 0; i < 8 && !done; i++) begin
         done = wr_ready_o;
         step();
      end
      wr_valid_i = 1'b0;
      if (!done) check("wr_timeout", 32'(0), 32'(1));
   endtask

   task automatic top_read(input string tag, input logic [9:0] x, input logic [19:0] mv,
                           input logic av, input bit cmp_mv);
      bit done = 0;
      top_rd_en_i = 1'b1; top_rd_x_i = x;
      #1;
      for (int i = 0; i < 8 && !done; i++) begin
         done = top_rd_ready_o;
         step();
      end
      top_rd_en_i = 1'b0;
      if (!done) check({tag, "_timeout"}, 32'(0), 32'(1));
      check({tag, "_av"}, 32'(top_rd_avail_o), 32'(av));
      if (cmp_mv) check({tag, "_mv"}, 32'(top_rd_mv_o), 32'(mv));
   endtask

   task automatic lft_read(input string tag, input logic [2:0] row, input logic [19:0] mv,
                           input logic av);
      lft_rd_en_i = 1'b1; lft_rd_row_i = row;
      step();
      lft_rd_en_i = 1'b0;
      check({tag, "_av"}, 32'(lft_rd_avail_o), 32'(av));
      check({tag, "_mv"}, 32'(lft_rd_mv_o), 32'(mv));
   endtask

   task automatic new_ctu(input logic [6:0] x);
      ctu_start_i = 1'b1; ctu_x_i = x;
      step();
      ctu_start_i = 1'b0;
   endtask

   initial begin
      rstn = 1'b0; frame_start_i = 1'b0; ctu_start_i = 1'b0; ctu_x_i = '0;
      wr_valid_i = 1'b0; wr_row_i = '0; wr_col_i = '0; wr_mv_i = '0;
      lft_rd_en_i = 1'b0; lft_rd_row_i = '0; top_rd_en_i = 1'b0; top_rd_x_i = '0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      #1;
      check("rst_wr_ready", 32'(wr_ready_o), 32'(1));
      check("rst_top_ready", 32'(top_rd_ready_o), 32'(1));
      check("rst_top_mv", 32'(top_rd_mv_o), 32'(0));
      check("rst_top_av", 32'(top_rd_avail_o), 32'(0));
      check("rst_lft_mv", 32'(lft_rd_mv_o), 32'(0));
      step();

      // Reads after reset see nothing available
      ctu_x_i = 7'd1;
      top_read("rst_top5", 10'd5, '0, 1'b0, 1'b0);
      lft_read("rst_lft3", 3'd3, '0, 1'b0);
      check("rst_wr_ready2", 32'(wr_ready_o), 32'(1));

      // Bottom-row write blocks the top port in its cycle
      ctu_x_i = 7'd2;
      wr_valid_i = 1'b1; wr_row_i = 3'd7; wr_col_i = 3'd3; wr_mv_i = 20'h0AB0F;
      top_rd_en_i = 1'b1; top_rd_x_i = 10'd19;
      #1;
      check("wr_blocks_top", 32'(top_rd_ready_o), 32'(0));
      step();
      wr_valid_i = 1'b0;
      #1;
      check("top_ready_after", 32'(top_rd_ready_o), 32'(1));
      step();
      top_rd_en_i = 1'b0;
      check("top19_mv", 32'(top_rd_mv_o), 32'h0AB0F);
      check("top19_av", 32'(top_rd_avail_o), 32'(1));
      step();
      check("top19_hold", 32'(top_rd_mv_o), 32'h0AB0F);

      // Left column of CTU 0, read back from CTU 1
      ctu_x_i = 7'd0;
      for (int k = 0; k < 8; k++) do_write(3'(k), 3'd7, 20'h00100 + 20'(k));
      step();
      ctu_x_i = 7'd1;
      for (int k = 0; k < 8; k++) lft_read("lft_bank0", 3'(k), 20'h00100 + 20'(k), 1'b1);
      ctu_x_i = 7'd2;
      lft_read("lft_bank1_empty", 3'd3, '0, 1'b0);
      ctu_x_i = 7'd0;
      lft_read("lft_ctu0", 3'd2, '0, 1'b0);

      // Corner capture: A then B at x=7, top-left sees A, array sees B
      do_write(3'd7, 3'd7, MV_A);
      step();
      wr_valid_i = 1'b1; wr_row_i = 3'd7; wr_col_i = 3'd7; wr_mv_i = MV_B;
      check("corner_rdy_before", 32'(wr_ready_o), 32'(1));
      step();
      wr_valid_i = 1'b0;
      check("corner_rdy_low", 32'(wr_ready_o), 32'(0));
      check("corner_top_blocked", 32'(top_rd_ready_o), 32'(0));
      step();
      check("corner_rdy_back", 32'(wr_ready_o), 32'(1));
      new_ctu(7'd1);
      top_read("tl_ctu1", 10'd7, MV_A, 1'b1, 1'b1);
      new_ctu(7'd2);
      top_read("arr_x7", 10'd7, MV_B, 1'b1, 1'b1);
      top_read("tl_ctu2", 10'd15, MV_A, 1'b1, 1'b1);

      // Wrap at the picture's left edge
      ctu_x_i = 7'd127;
      do_write(3'd7, 3'd7, 20'h12345);
      top_read("x1023", 10'd1023, 20'h12345, 1'b1, 1'b1);
      ctu_x_i = 7'd0;
      top_read("wrap", 10'd1023, '0, 1'b0, 1'b1);

      // Frame start during W_CAP
      ctu_x_i = 7'd3;
      wr_valid_i = 1'b1; wr_row_i = 3'd7; wr_col_i = 3'd7; wr_mv_i = 20'hCCCCC;
      step();
      wr_valid_i = 1'b0; frame_start_i = 1'b1;
      step();
      frame_start_i = 1'b0;
      check("frame_fsm_idle", 32'(wr_ready_o), 32'(1));
      top_read("frame_x31", 10'd31, '0, 1'b0, 1'b0);
      top_read("frame_x19", 10'd19, '0, 1'b0, 1'b0);
      top_read("frame_x7", 10'd7, '0, 1'b0, 1'b0);
      lft_read("frame_lft", 3'd2, 20'h00102, 1'b0);
      // Write coincident with frame start is dropped
      ctu_x_i = 7'd4;
      wr_valid_i = 1'b1; wr_row_i = 3'd7; wr_col_i = 3'd1; wr_mv_i = 20'h77777;
      frame_start_i = 1'b1;
      step();
      wr_valid_i = 1'b0; frame_start_i = 1'b0;
      top_read("frame_drop_x33", 10'd33, '0, 1'b0, 1'b0);
      new_ctu(7'd4);
      top_read("frame_tl", 10'd31, '0, 1'b0, 1'b1);

      // Reset during W_CAP
      ctu_x_i = 7'd5;
      do_write(3'd7, 3'd7, 20'h11111);
      do_write(3'd7, 3'd7, 20'h22222);
      step();
      new_ctu(7'd6);
      top_read("pre_rst_tl", 10'd47, 20'h11111, 1'b1, 1'b1);
      wr_valid_i = 1'b1; wr_row_i = 3'd7; wr_col_i = 3'd7; wr_mv_i = 20'h33333;
      step();
      wr_valid_i = 1'b0;
      rstn = 1'b0;
      #3 rstn = 1'b1;
      step();
      check("rst_cap_ready", 32'(wr_ready_o), 32'(1));
      top_read("rst_cap_x55", 10'd55, '0, 1'b0, 1'b0);
      top_read("rst_cap_tl", 10'd47, '0, 1'b0, 1'b1);
      ctu_x_i = 7'd7;
      lft_read("rst_cap_lft", 3'd7, '0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
